cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 23 ++
 rtl/cdb_arbiter_if.sv | 28 ++
 rtl/cdb_arbiter_rr_pick.sv | 33 +++
 rtl/cdb_arbiter.sv | 71 +++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus arbiter: default widths,
// requester indices, the invalid-op code and a saturating counter helper.
package cdb_arbiter_pkg;

  localparam int N_REQ_DEF  = 3;
  localparam int TAG_W_DEF  = 4;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 16;
  localparam int SRC_W      = 2;

  typedef enum logic [SRC_W-1:0] {
    SRC_ALU = 2'd0,
    SRC_LSB = 2'd1,
    SRC_BRU = 2'd2
  } src_e;

  localparam logic [4:0] OP_INVALID = 5'b11111;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester handshake and broadcast bus of the CDB arbiter. The arbiter
// takes the slave side; functional units and the bench take the master side.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*TAG_W-1:0]  req_tag;
  logic [N_REQ*DATA_W-1:0] req_value;
  logic [N_REQ-1:0]        req_ready;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]       cdb_value;
  logic [SRC_W-1:0]        cdb_src;

  modport master (
    output req_valid, req_tag, req_value,
    input  req_ready, cdb_valid, cdb_tag, cdb_value, cdb_src
  );

  modport slave (
    input  req_valid, req_tag, req_value,
    output req_ready, cdb_valid, cdb_tag, cdb_value, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Rotating priority encoder: the first set bit of i_valid at or after i_ptr
// (wrapping) wins, reported both one-hot and as an index.
module rr_pick #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     i_valid,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_any
);

  // Scanning the doubled vector from i_ptr upward performs the wrap for free.
  logic [2*N-1:0] w_dbl;
  assign w_dbl = {i_valid, i_valid};

  // NOTE: every output gets a default before the loop, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    o_any   = 1'b0;
    o_idx   = '0;
    o_grant = '0;
    for (int k = 0; k < 2 * N; k++) begin
      if (!o_any && k >= int'(i_ptr) && w_dbl[k]) begin
        o_any = 1'b1;
        o_idx = PTR_W'((k < N) ? k : k - N);
      end
    end
    if (o_any) o_grant[o_idx] = 1'b1;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: one result per cycle is
// broadcast one cycle after its transfer, with per-source saturating counters.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  cdb_arbiter_if.slave           bus,
  output logic [N_REQ*CNT_W-1:0] o_bcast_cnt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]            r_rr_ptr;
  logic                        r_cdb_valid;
  logic [TAG_W-1:0]            r_cdb_tag;
  logic [DATA_W-1:0]           r_cdb_value;
  logic [SRC_W-1:0]            r_cdb_src;
  logic [N_REQ-1:0][CNT_W-1:0] r_bcast_cnt;

  logic [N_REQ-1:0] w_grant;
  logic [PTR_W-1:0] w_idx;
  logic             w_any;
  logic             w_xfer;

  rr_pick #(.N(N_REQ), .PTR_W(PTR_W)) u_pick (
    .i_valid (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Grants are suppressed during reset and squash so nothing is consumed.
  assign bus.req_ready = (rst && !i_flush) ? w_grant : '0;
  assign w_xfer        = w_any && rst && !i_flush;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rr_ptr    <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_value <= '0;
      r_cdb_src   <= '0;
      r_bcast_cnt <= '0;
    end else begin
      r_cdb_valid <= w_xfer;
      if (w_xfer) begin
        r_rr_ptr    <= (w_idx == PTR_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
        r_cdb_tag   <= bus.req_tag[w_idx*TAG_W +: TAG_W];
        r_cdb_value <= bus.req_value[w_idx*DATA_W +: DATA_W];
        r_cdb_src   <= SRC_W'(w_idx);
        r_bcast_cnt[w_idx] <= sat_inc(r_bcast_cnt[w_idx]);
      end
    end
  end

  assign bus.cdb_valid = r_cdb_valid;
  assign bus.cdb_tag   = r_cdb_tag;
  assign bus.cdb_value = r_cdb_value;
  assign bus.cdb_src   = r_cdb_src;
  assign o_bcast_cnt   = r_bcast_cnt;

endmodule
